// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier: one multiplier bit per clock,
// registered product halves, and a one-cycle ld pulse for the downstream register.
module seq_multiplier #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cl,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  ld,
    output logic [DATA_WIDTH-1:0] out,
    output logic [DATA_WIDTH-1:0] out_hi,
    output logic                  ovf
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [DATA_WIDTH-1:0]   r_mcand;
    logic [DATA_WIDTH-1:0]   r_mplier;
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [CW-1:0]           r_count;
    logic [DATA_WIDTH-1:0]   r_out;
    logic [DATA_WIDTH-1:0]   r_out_hi;
    logic                    r_ovf;

    logic [DATA_WIDTH:0]     w_sum;
    logic [2*DATA_WIDTH-1:0] w_acc_step;
    logic                    w_last;
    logic                    w_accept;

    // Add into the upper half with its carry, then shift the whole accumulator right.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                   + (r_mplier[0] ? {1'b0, r_mcand} : '0);
        w_acc_step = (2*DATA_WIDTH)'({w_sum, r_acc[DATA_WIDTH-1:0]} >> 1);
        w_last     = (r_count == CW'(DATA_WIDTH - 1));
        w_accept   = start && !cl;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        ld     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (cl)          w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b1;
                ld     = !cl;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_out    <= '0;
            r_out_hi <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                S_RUN: begin
                    if (!cl) begin
                        r_acc    <= w_acc_step;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + CW'(1);
                        // Product registers change only on the edge that enters DONE.
                        if (w_last) begin
                            r_out    <= w_acc_step[DATA_WIDTH-1:0];
                            r_out_hi <= w_acc_step[2*DATA_WIDTH-1:DATA_WIDTH];
                            r_ovf    <= |w_acc_step[2*DATA_WIDTH-1:DATA_WIDTH];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out    = r_out;
    assign out_hi = r_out_hi;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: table-driven products plus hand-written
// sequences for ignored start, cl abort and asynchronous reset mid-operation.
module tb_seq_multiplier;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         cl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         ld;
    logic [W-1:0] out;
    logic [W-1:0] out_hi;
    logic         ovf;

    logic [W-1:0] dreg;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    seq_multiplier #(.DATA_WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cl     (cl),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .ld     (ld),
        .out    (out),
        .out_hi (out_hi),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // Downstream data register fed by out/ld.
    always @(posedge clk or posedge rst) begin
        if (rst)     dreg <= '0;
        else if (ld) dreg <= out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Runs one operation; poke_k / cl_k are cycle indices after acceptance (-1 = unused).
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input int poke_k, input int cl_k,
                          output int ld_cnt, output int ld_pos, output int busy_cnt);
        @(negedge clk);
        a = va; b = vb; start = 1'b1; cl = 1'b0;
        @(posedge clk);
        ld_cnt = 0; ld_pos = -1; busy_cnt = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ld) begin
                ld_cnt++;
                ld_pos = k;
            end
            if (!busy) begin
                busy_cnt = k - 1;
                break;
            end
            start = 1'b0;
            cl    = 1'b0;
            if (k == poke_k) begin
                start = 1'b1; a = 16'd9; b = 16'd9;
            end
            if (k == poke_k + 1) begin
                a = 16'h5555; b = 16'hAAAA;
            end
            if (k == cl_k) cl = 1'b1;
        end
        start = 1'b0;
        cl    = 1'b0;
    endtask

    int ld_cnt, ld_pos, busy_cnt;

    initial begin
        vecs[0] = '{16'd3,    16'd5,    16'd15,   16'h0000, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1};
        vecs[2] = '{16'h0100, 16'h0100, 16'h0000, 16'h0001, 1'b1};
        vecs[3] = '{16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{16'hABCD, 16'h1234, 16'h4FA4, 16'h0C37, 1'b1};
        vecs[5] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
        vecs[6] = '{16'h8000, 16'h0002, 16'h0000, 16'h0001, 1'b1};

        rst = 1'b1; start = 1'b0; cl = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_ld",     {31'd0, ld},   32'd0);
        check("rst_out",    {16'd0, out},  32'd0);
        check("rst_out_hi", {16'd0, out_hi}, 32'd0);
        check("rst_ovf",    {31'd0, ovf},  32'd0);
        rst = 1'b0;

        // cl alone and start together with cl must both leave the unit idle.
        @(negedge clk); cl = 1'b1;
        @(negedge clk); check("cl_idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; a = 16'd7; b = 16'd7;
        @(negedge clk); check("start_cl_busy", {31'd0, busy}, 32'd0);
        start = 1'b0; cl = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, -1, -1, ld_cnt, ld_pos, busy_cnt);
            check($sformatf("v%0d_ld_cnt", i),  ld_cnt,   32'd1);
            check($sformatf("v%0d_ld_pos", i),  ld_pos,   32'd17);
            check($sformatf("v%0d_busy", i),    busy_cnt, 32'd17);
            check($sformatf("v%0d_out", i),     {16'd0, out},    {16'd0, vecs[i].lo});
            check($sformatf("v%0d_out_hi", i),  {16'd0, out_hi}, {16'd0, vecs[i].hi});
            check($sformatf("v%0d_ovf", i),     {31'd0, ovf},    {31'd0, vecs[i].ovf});
            check($sformatf("v%0d_dreg", i),    {16'd0, dreg},   {16'd0, vecs[i].lo});
        end

        // Start during RUN with different operands is ignored.
        run_op(16'd7, 16'd6, 5, -1, ld_cnt, ld_pos, busy_cnt);
        check("ign_ld_cnt", ld_cnt,   32'd1);
        check("ign_ld_pos", ld_pos,   32'd17);
        check("ign_busy",   busy_cnt, 32'd17);
        check("ign_out",    {16'd0, out},  32'd42);
        check("ign_dreg",   {16'd0, dreg}, 32'd42);
        @(negedge clk);
        check("ign_no_rerun", {31'd0, busy}, 32'd0);

        // Abort at RUN cycle 8: no ld, outputs keep the previous product.
        run_op(16'd2, 16'd2, -1, 8, ld_cnt, ld_pos, busy_cnt);
        check("cl_ld_cnt", ld_cnt,   32'd0);
        check("cl_busy",   busy_cnt, 32'd8);
        check("cl_out",    {16'd0, out},  32'd42);
        check("cl_ovf",    {31'd0, ovf},  32'd0);
        check("cl_dreg",   {16'd0, dreg}, 32'd42);
        run_op(16'd2, 16'd2, -1, -1, ld_cnt, ld_pos, busy_cnt);
        check("after_cl_ld_cnt", ld_cnt, 32'd1);
        check("after_cl_out", {16'd0, out},  32'd4);
        check("after_cl_dreg", {16'd0, dreg}, 32'd4);

        // Asynchronous reset between edges in the middle of RUN.
        @(negedge clk);
        a = 16'd3; b = 16'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_out",  {16'd0, out},  32'd4);
        #2 rst = 1'b1;
        #1;
        check("arst_busy",   {31'd0, busy},   32'd0);
        check("arst_ld",     {31'd0, ld},     32'd0);
        check("arst_out",    {16'd0, out},    32'd0);
        check("arst_out_hi", {16'd0, out_hi}, 32'd0);
        check("arst_ovf",    {31'd0, ovf},    32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'd3, 16'd5, -1, -1, ld_cnt, ld_pos, busy_cnt);
        check("post_rst_ld_pos", ld_pos, 32'd17);
        check("post_rst_out", {16'd0, out},  32'd15);
        check("post_rst_dreg", {16'd0, dreg}, 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Multi-cycle unsigned shift-and-add multiplier. It sits directly upstream of the general-purpose data register.
- Its `out` drives the register's `in`, and its `ld` pulse drives the register's `ld`. Each completed product is therefore loaded into the register exactly once.
- Fixed latency, one multiplier bit per clock. Lets the CPU datapath multiply without a combinational array.

Parameters:
- DATA_WIDTH, 16, width of each operand and of the low/high product halves.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply. Sampled only in IDLE.
- cl  input  1  synchronous abort. Returns to IDLE with no ld pulse.
- a  input  DATA_WIDTH  multiplicand, captured when start is accepted.
- b  input  DATA_WIDTH  multiplier, captured when start is accepted.
- busy  output  1  high in RUN and DONE.
- ld  output  1  one-cycle pulse. High only in DONE; connects to the register's ld.
- out  output  DATA_WIDTH  low half of the product; connects to the register's in.
- out_hi  output  DATA_WIDTH  high half of the product.
- ovf  output  1  high when out_hi is nonzero.

Behaviour:
- Interface: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset, applied at any time including mid-operation:
  - state goes to IDLE, all internal registers clear;
  - busy=0, ld=0, out=0, out_hi=0, ovf=0.
- States are IDLE, RUN and DONE, with a bit counter of width clog2(DATA_WIDTH)+1.
- IDLE:
  - start=1 and cl=0 at an edge: capture a into the multiplicand and b into the multiplier shift register, clear the 2*DATA_WIDTH accumulator, set count=0, go to RUN.
  - start=0, or start=1 with cl=1: stay in IDLE.
- RUN, at each edge:
  - if multiplier[0]=1, add the multiplicand to the upper DATA_WIDTH+1 bits of the accumulator, carry included;
  - shift the accumulator right by 1 and the multiplier right by 1;
  - count++.
  - After the DATA_WIDTH-th RUN edge, go to DONE.
- DONE:
  - ld=1 for exactly this one cycle;
  - at the next edge, go to IDLE.
- Latency:
  - start accepted at edge E0;
  - ld is high during the cycle following edge E(DATA_WIDTH+0), i.e. 16 edges after E0 at the default width, plus the DONE cycle;
  - next start is accepted no earlier than the edge that ends DONE.
- Latency is fixed regardless of operand values. There is no early exit for zero operands.
- Arithmetic:
  - product = a*b, unsigned, 2*DATA_WIDTH bits, exact, no truncation inside the unit;
  - out = product[DATA_WIDTH-1:0];
  - out_hi = product[2*DATA_WIDTH-1:DATA_WIDTH];
  - ovf = |out_hi.
- Output registers:
  - out, out_hi and ovf are registered. They update on the edge entering DONE.
  - They hold their value through IDLE and the next RUN until the next DONE. The register downstream only sees new data with ld.
- start while busy (RUN or DONE): ignored. There is no queueing and no effect on the operation in progress.
- cl:
  - in RUN or DONE: return to IDLE at that edge, ld stays 0, out/out_hi/ovf are unchanged;
  - cl has priority over start;
  - cl in IDLE has no effect.
- Changes to a or b after acceptance have no effect on the result.

Test Plan:
- Reset, then a=3, b=5, start for 1 cycle -> busy=1 for 17 cycles; ld=1 on exactly one cycle, 17 cycles after acceptance; out=15, out_hi=0, ovf=0. The downstream register holds 15.
- a=0xFFFF, b=0xFFFF -> out=0x0001, out_hi=0xFFFE, ovf=1. Also a=0x0100, b=0x0100 -> out=0x0000, out_hi=0x0001, ovf=1.
- a=0, b=0x1234 -> latency still 17 cycles; out=0, ovf=0.
- Start a=7, b=6. At cycle 5, pulse start with a=9, b=9, and change a/b inputs -> second start ignored; result out=42 with a single ld pulse.
- Start a=2, b=2; assert cl at RUN cycle 8 -> no ld pulse; busy drops after that edge; out keeps its previous value (42). A new start 2*2 next cycle -> out=4.
- Assert rst mid-RUN, asynchronously between edges -> busy, ld, out, out_hi and ovf go to 0 immediately. After rst releases, 3*5 completes normally with out=15.
